mem_access_unit: RTL and testbench

CPU-side initiator for the byte-addressed data RAM. Accepts one load/store request at a time from the datapath and drives the RAM's `addr`/`data_in`/`data_read`/`data_write` interface. Handles alignment checking, read-modify-write for sub-word stores (the RAM always writes four bytes), and sign/zero extension of sub-word loads. Sits between the CPU's memory stage and the RAM; the datapath stalls while `req_ready` is low.

---
 rtl/mem_pkg.sv | 71 +++++++
 rtl/mem_lane_align.sv | 18 +
 rtl/mem_access_unit.sv | 151 +++++++++++++++
 tb/tb_mem_access_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the data-memory access unit.
// Holds size/state enums, alignment check, store merge and load extend.
package mem_pkg;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } mau_state_t;

  localparam int DATA_W = 32;

  function automatic logic misaligned(
    input mem_size_t  sz,
    input logic [1:0] off
  );
    logic r;
    unique case (sz)
      BYTE:    r = 1'b0;
      HALF:    r = off[0];
      WORD:    r = |off;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Replace the addressed lane(s) of the word; word stores pass wdata.
  function automatic logic [31:0] lane_merge(
    input logic [1:0]  off,
    input mem_size_t   sz,
    input logic [31:0] word,
    input logic [31:0] wdata
  );
    logic [31:0] r;
    r = word;
    unique case (sz)
      BYTE:    r[{off, 3'b000} +: 8]        = wdata[7:0];
      HALF:    r[{off[1], 4'b0000} +: 16]   = wdata[15:0];
      default: r = wdata;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(
    input logic [1:0]  off,
    input mem_size_t   sz,
    input logic        sext,
    input logic [31:0] word
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    unique case (sz)
      BYTE:    r = {{24{sext & b[7]}}, b};
      HALF:    r = {{16{sext & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering between a 32-bit RAM word and the datapath.
// Ports: offset/size/is_signed/word/wdata in; merged (store), loaded (load) out.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  offset,
  input  mem_size_t   size,
  input  logic        is_signed,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] loaded
);

  assign merged = lane_merge(offset, size, word, wdata);
  assign loaded = load_extend(offset, size, is_signed, word);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the byte-addressed data RAM with RMW sub-word stores.
// Ports: req_* handshake in, rsp_* completion out, mem_* RAM interface.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  mau_state_t        state;
  mau_state_t        next;
  logic              we_q;
  mem_size_t         size_q;
  logic              sgn_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;

  logic              err_now;
  logic [31:0]       align_word;
  logic [31:0]       merged;
  logic [31:0]       loaded;
  logic [ADDR_W-1:0] word_addr;

  assign err_now   = misaligned(mem_size_t'(req_size), req_addr[1:0]);
  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

  // READ extends the live RAM word; WRITE merges into the captured one.
  assign align_word = (state == READ) ? mem_rdata : word_q;

  mem_lane_align u_align (
    .offset    (addr_q[1:0]),
    .size      (size_q),
    .is_signed (sgn_q),
    .word      (align_word),
    .wdata     (wdata_q),
    .merged    (merged),
    .loaded    (loaded)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          priority case (1'b1)
            err_now:                       next = RESP;
            !req_we:                       next = READ;
            mem_size_t'(req_size) == WORD: next = WRITE;
            default:                       next = READ;
          endcase
        end
      end
      READ:    next = we_q ? WRITE : RESP;
      WRITE:   next = RESP;
      RESP:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      IDLE: req_ready = 1'b1;
      READ: begin
        mem_read = 1'b1;
        mem_addr = word_addr;
      end
      WRITE: begin
        mem_write = 1'b1;
        mem_addr  = word_addr;
        mem_wdata = merged;
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request latch, RMW word capture and held response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      size_q    <= BYTE;
      sgn_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      word_q    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= mem_size_t'(req_size);
            sgn_q   <= req_signed;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (err_now) begin
              rsp_rdata <= '0;
              rsp_err   <= 1'b1;
            end
          end
        end
        READ: begin
          word_q <= mem_rdata;
          if (!we_q) begin
            rsp_rdata <= loaded;
            rsp_err   <= 1'b0;
          end
        end
        WRITE: begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit with a byte RAM model.
// Expected responses are queued at drive time and checked on rsp_valid.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  logic [7:0] ram [0:1023];
  logic [9:0] wa;
  assign wa = {mem_addr[9:2], 2'b00};
  assign mem_rdata = {ram[wa + 10'd3], ram[wa + 10'd2],
                      ram[wa + 10'd1], ram[wa]};

  int          rd_cnt;
  int          wr_cnt;
  int          both_cnt;
  int          rsp_cnt;
  logic [31:0] w_addr;
  logic [31:0] w_data;

  always @(posedge clk) begin
    if (mem_read) rd_cnt++;
    if (mem_write) begin
      wr_cnt++;
      w_addr = mem_addr;
      w_data = mem_wdata;
      ram[wa]         = mem_wdata[7:0];
      ram[wa + 10'd1] = mem_wdata[15:8];
      ram[wa + 10'd2] = mem_wdata[23:16];
      ram[wa + 10'd3] = mem_wdata[31:24];
    end
    if (mem_read && mem_write) both_cnt++;
  end

  always @(negedge clk) begin
    if (rsp_valid) rsp_cnt++;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          reads;
    int          writes;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input logic [9:0] a, input logic [31:0] w);
    ram[a]         = w[7:0];
    ram[a + 10'd1] = w[15:8];
    ram[a + 10'd2] = w[23:16];
    ram[a + 10'd3] = w[31:24];
  endtask

  function automatic logic [31:0] get_word(input logic [9:0] a);
    return {ram[a + 10'd3], ram[a + 10'd2], ram[a + 10'd1], ram[a]};
  endfunction

  task automatic do_req(
    input string       tag,
    input logic        we,
    input logic [1:0]  size,
    input logic        sgn,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [31:0] e_rdata,
    input logic        e_err,
    input int          e_lat,
    input int          e_rd,
    input int          e_wr,
    input logic [31:0] e_waddr,
    input logic [31:0] e_wdata
  );
    exp_t e;
    int   cyc;
    @(negedge clk);
    chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    rd_cnt     = 0;
    wr_cnt     = 0;
    both_cnt   = 0;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    e.rdata  = e_rdata;
    e.err    = e_err;
    e.lat    = e_lat;
    e.reads  = e_rd;
    e.writes = e_wr;
    e.waddr  = e_waddr;
    e.wdata  = e_wdata;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = $urandom;
    req_wdata = $urandom;
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) break;
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, cyc, e.lat);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    chk({tag, "_rdata"}, rsp_rdata, e.rdata);
    chk({tag, "_err"}, {31'b0, rsp_err}, {31'b0, e.err});
    chk({tag, "_busy_ready"}, {31'b0, req_ready}, 32'd0);
    chk({tag, "_reads"}, rd_cnt, e.reads);
    chk({tag, "_writes"}, wr_cnt, e.writes);
    chk({tag, "_overlap"}, both_cnt, 32'd0);
    if (e.writes > 0) begin
      chk({tag, "_waddr"}, w_addr, e.waddr);
      chk({tag, "_wdata"}, w_data, e.wdata);
    end
  endtask

  initial begin
    rst_n      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    rd_cnt     = 0;
    wr_cnt     = 0;
    both_cnt   = 0;
    rsp_cnt    = 0;
    w_addr     = '0;
    w_data     = '0;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    set_word(10'h100, 32'h12345678);
    set_word(10'h108, 32'h01020304);

    #2 rst_n = 1'b0;
    #20;
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;

    do_req("ld_w", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0,
           32'h12345678, 1'b0, 2, 1, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("hold_valid", {31'b0, rsp_valid}, 32'd0);
    chk("hold_rdata", rsp_rdata, 32'h12345678);

    ram[10'h103] = 8'h80;
    do_req("ld_bs", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0,
           32'hFFFFFF80, 1'b0, 2, 1, 0, 32'h0, 32'h0);
    do_req("ld_bu", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0,
           32'h00000080, 1'b0, 2, 1, 0, 32'h0, 32'h0);

    set_word(10'h100, 32'h11223344);
    do_req("st_h", 1'b1, 2'b01, 1'b0, 32'h102, 32'h1234BEEF,
           32'h0, 1'b0, 3, 1, 1, 32'h100, 32'hBEEF3344);
    do_req("ld_mis", 1'b0, 2'b10, 1'b0, 32'h101, 32'h0,
           32'h0, 1'b1, 1, 0, 0, 32'h0, 32'h0);
    do_req("ld_ill", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0,
           32'h0, 1'b1, 1, 0, 0, 32'h0, 32'h0);

    do_req("st_w", 1'b1, 2'b10, 1'b0, 32'h104, 32'hCAFEF00D,
           32'h0, 1'b0, 2, 0, 1, 32'h104, 32'hCAFEF00D);
    do_req("ld_b2b", 1'b0, 2'b10, 1'b0, 32'h104, 32'h0,
           32'hCAFEF00D, 1'b0, 2, 1, 0, 32'h0, 32'h0);

    do_req("st_b", 1'b1, 2'b00, 1'b0, 32'h101, 32'hFFFFFFA5,
           32'h0, 1'b0, 3, 1, 1, 32'h100, 32'hBEEFA544);
    do_req("ld_hu", 1'b0, 2'b01, 1'b0, 32'h100, 32'h0,
           32'h0000A544, 1'b0, 2, 1, 0, 32'h0, 32'h0);
    do_req("ld_hs", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0,
           32'hFFFFBEEF, 1'b0, 2, 1, 0, 32'h0, 32'h0);
    do_req("st_hmis", 1'b1, 2'b01, 1'b0, 32'h103, 32'h5555,
           32'h0, 1'b1, 1, 0, 0, 32'h0, 32'h0);
    chk("ram_after_err", get_word(10'h100), 32'hBEEFA544);

    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h108;
    req_wdata  = 32'h5A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rsp_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_write_on", {31'b0, mem_write}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_write_off", {31'b0, mem_write}, 32'd0);
    chk("rst_mid_read_off", {31'b0, mem_read}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_mid_no_rsp", rsp_cnt, 32'd0);
    chk("rst_mid_ram", get_word(10'h108), 32'h01020304);

    do_req("ld_after_rst", 1'b0, 2'b10, 1'b0, 32'h108, 32'h0,
           32'h01020304, 1'b0, 2, 1, 0, 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
